// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode encoding, instruction field positions,
// the NOP word and the instruction-stream controller state type.
package cpu_defs_pkg;

  // Opcode field width and position within a 16-bit instruction word.
  localparam int OP_W   = 5;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;

  // First register field position.
  localparam int R1_MSB = 10;
  localparam int R1_LSB = 8;

  // Opcode encoding shared with the CPU core.
  localparam logic [OP_W-1:0] NOP   = 5'b00000;
  localparam logic [OP_W-1:0] HALT  = 5'b00001;
  localparam logic [OP_W-1:0] LOAD  = 5'b00010;
  localparam logic [OP_W-1:0] STORE = 5'b00011;
  localparam logic [OP_W-1:0] ADD   = 5'b00100;
  localparam logic [OP_W-1:0] SUB   = 5'b00101;

  // All-zero instruction: the pipeline bubble.
  localparam logic [15:0] NOP_WORD = 16'h0000;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/prog_buffer.sv
// Program buffer: 2**AW words of IW bits, written synchronously,
// read combinationally so the controller can register the fetched word.
module prog_buffer
  import cpu_defs_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [2**AW];

  // Word write, visible on the read port from the next cycle.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_ctrl.sv
// Instruction stream controller: holds a program, pulses the CPU start
// strobe on a run request, streams one word per unpaused cycle, then
// flushes the pipeline with NOPs once HALT has been issued.
module instr_stream_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int AW           = 8,
  parameter int IW           = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          run,
  input  logic          pause,
  output logic [IW-1:0] i_datain,
  output logic          cpu_enable,
  output logic          cpu_start,
  output logic          busy,
  output logic          done,
  output logic          prog_err,
  output logic [AW:0]   issued
);

  localparam int            DW       = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] PTR_LAST = '1;
  localparam logic [IW-1:0] NOP_OUT  = IW'(NOP_WORD);
  localparam logic [IW-1:0] HALT_OUT = {HALT, {(IW-OP_W){1'b0}}};

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic [AW:0]   issued_reg, issued_next;
  logic [IW-1:0] data_reg, data_next;
  logic          en_reg, en_next;
  logic          err_reg, err_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          force_halt_reg, force_halt_next;
  logic [IW-1:0] rd_word;
  logic          buf_we;

  // Writes only land while idle and out of reset; other writes are flagged.
  assign buf_we = reset && prog_we && (state_reg == IDLE);

  prog_buffer #(
    .AW(AW),
    .IW(IW)
  ) u_prog_buffer (
    .clock(clock),
    .we   (buf_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(ptr_reg),
    .rdata(rd_word)
  );

  // Next-state, pointer, counters and next instruction word.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    issued_next     = issued_reg;
    data_next       = data_reg;
    drain_next      = drain_reg;
    force_halt_next = force_halt_reg;
    err_next        = prog_we && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        data_next = NOP_OUT;
        if (run && !prog_we) begin
          state_next      = START;
          ptr_next        = '0;
          issued_next     = '0;
          drain_next      = '0;
          force_halt_next = 1'b0;
        end
      end
      // START issues buf[0] on its way out so it lands the cycle after the
      // start pulse; STREAM keeps issuing one word per unpaused cycle.
      START, STREAM: begin
        state_next = STREAM;
        if (!pause) begin
          issued_next = issued_reg + (AW+1)'(1);
          if (force_halt_reg) begin
            data_next  = HALT_OUT;
            state_next = DRAIN;
          end else begin
            data_next = rd_word;
            if (rd_word[OP_MSB:OP_LSB] == HALT) begin
              state_next = DRAIN;
            end else if (ptr_reg == PTR_LAST) begin
              force_halt_next = 1'b1;
            end else begin
              ptr_next = ptr_reg + AW'(1);
            end
          end
        end
      end
      // HALT is on i_datain on entry; then DRAIN_CYCLES NOPs, then DONE.
      DRAIN: begin
        if (!pause) begin
          if (drain_reg == DW'(DRAIN_CYCLES)) begin
            state_next = DONE;
          end else begin
            drain_next = drain_reg + DW'(1);
            data_next  = NOP_OUT;
          end
        end
      end
      DONE: begin
        data_next = NOP_OUT;
        if (!run) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    en_next = ((state_next == IDLE) || (state_next == DONE)) ? 1'b1 : !pause;
  end

  // State and registered outputs; reset leaves the buffer contents alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      issued_reg     <= '0;
      data_reg       <= NOP_OUT;
      en_reg         <= 1'b0;
      err_reg        <= 1'b0;
      drain_reg      <= '0;
      force_halt_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      issued_reg     <= issued_next;
      data_reg       <= data_next;
      en_reg         <= en_next;
      err_reg        <= err_next;
      drain_reg      <= drain_next;
      force_halt_reg <= force_halt_next;
    end
  end

  assign i_datain   = data_reg;
  assign cpu_enable = en_reg;
  assign cpu_start  = (state_reg == START);
  assign busy       = (state_reg == START) || (state_reg == STREAM) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign prog_err   = err_reg;
  assign issued     = issued_reg;

endmodule

// File: doc/instr_stream_ctrl.md
Name: instr_stream_ctrl

Overview:
- Sits directly upstream of the CPU core and feeds its instruction port.
- Holds a program in a local buffer that is written word-by-word while idle.
- On a run request it pulses the CPU start strobe, then presents one 16-bit instruction on i_datain per enabled cycle.
- After HALT issues, it flushes the pipeline with NOPs and reports completion.

Parameters:
- AW, 8, program-buffer address width; depth = 2**AW words.
- IW, 16, instruction width.
- DRAIN_CYCLES, 4, number of NOPs issued after HALT to flush the 5-stage pipeline.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- prog_we  in  1  program-buffer write strobe; honoured only in IDLE.
- prog_addr  in  AW  program-buffer write address.
- prog_data  in  IW  program word to write.
- run  in  1  level request to execute the stored program.
- pause  in  1  stalls streaming while high.
- i_datain  out  IW  registered instruction to the CPU.
- cpu_enable  out  1  CPU enable, equal to registered !pause.
- cpu_start  out  1  one-cycle CPU start pulse.
- busy  out  1  high in START, STREAM and DRAIN.
- done  out  1  high in DONE.
- prog_err  out  1  one-cycle pulse when prog_we is asserted outside IDLE; that write is dropped.
- issued  out  AW+1  count of program words issued, excluding drain NOPs.

Behaviour:
- Reset (reset==0 at a clock edge), applicable at any time including mid-stream:
  - State goes to IDLE.
  - i_datain=NOP word (16'h0000), cpu_start=0, cpu_enable=0, busy=0, done=0, prog_err=0, issued=0, read pointer=0.
  - Buffer contents are not cleared.
- IDLE:
  - cpu_enable=1.
  - prog_we writes the buffer, taking effect next cycle.
  - run==1 with prog_we==0 moves to START.
  - run and prog_we both high in the same cycle: the write wins and run is re-sampled next cycle.
- START (exactly 1 cycle):
  - cpu_start=1, i_datain=NOP.
  - Always moves to STREAM.
- STREAM, each cycle with pause==0:
  - i_datain <= buf[ptr]; ptr++; issued++.
  - Latency: buf[0] appears on i_datain the cycle after cpu_start is high.
  - Buffer read is combinational; the output is registered.
- STREAM with pause==1:
  - ptr, issued and i_datain hold their values.
  - cpu_enable drops in the same registered cycle.
- HALT detection: if the issued word has opcode [15:11]==HALT, the next state is DRAIN.
- Wrap-around: if ptr==2**AW-1 and that word is not HALT:
  - The word is issued.
  - The following cycle issues a forced HALT word {HALT,11'b0}; issued counts it.
  - Then the state moves to DRAIN.
  - ptr never wraps back to 0.
- DRAIN:
  - Issues NOP for DRAIN_CYCLES unpaused cycles; pause stalls the drain counter.
  - Then moves to DONE.
- DONE:
  - done=1, busy=0, i_datain=NOP, cpu_enable=1.
  - Holds until run==0, then returns to IDLE with ptr=0. issued is kept until the next START, where it clears.
- prog_we outside IDLE: the write is dropped and prog_err pulses for 1 cycle.
- run deasserted mid-STREAM is ignored; execution continues to HALT.
- Invariant: cpu_start is high for exactly one cycle per run.

Decomposition:
- Shared package cpu_defs_pkg:
  - Opcode constants NOP=5'b00000, HALT=5'b00001, LOAD, STORE, ADD, etc., identical to the CPU core's encoding.
  - Instruction field slices: op[15:11], r1[10:8].
  - NOP_WORD constant.
  - State enum {IDLE, START, STREAM, DRAIN, DONE}.
- One natural sub-module, prog_buffer: 2**AW x IW, synchronous write, asynchronous read.
- The FSM, pointer and counters live in the top module.

Test Plan:
1. Write buf[0..2]={LOAD r1,0x02}, {ADD r3,r1,r2}, {HALT}; raise run.
   - cpu_start high for 1 cycle.
   - Next 3 cycles i_datain = those words in order, then 4 cycles of 16'h0000.
   - done=1; issued=3.
2. Same program with pause=1 for 2 cycles after the first word.
   - i_datain holds the LOAD word for 2 extra cycles; cpu_enable=0 during those cycles.
   - Order is unchanged; issued=3.
3. Fill all 256 words with NOP, no HALT, run.
   - 256 NOPs, then 16'h0800 (forced HALT), then 4 NOPs.
   - done=1; issued=257.
4. Assert prog_we during STREAM.
   - prog_err pulses once; the buffer word is unchanged, checked via rerun.
5. Assert reset=0 for 1 cycle mid-STREAM.
   - Next cycle: IDLE, i_datain=0, busy=0, issued=0.
   - A rerun streams from buf[0] again.
6. Hold run high through DONE.
   - done stays 1 and no second cpu_start occurs.
   - Dropping run returns to IDLE; raising run again produces one new start pulse.
